// File: rtl/hilo_divider.sv
// hilo_divider: multi-cycle restoring (radix-2) divider serving the execute-stage
// ALU's DIV/DIVU requests. One quotient bit is produced per clock; the final
// {remainder, quotient} pair is registered onto result_o for the HI/LO write.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
//   opdata1_i     dividend; sampled with start_i
//   opdata2_i     divisor; sampled with start_i
//   start_i       request, held high by the ALU until ready_o is seen
//   annul_i       abort the operation in flight (pipeline flush)
//   result_o      [2W-1:W] remainder (HI), [W-1:0] quotient (LO)
//   ready_o       result_o valid
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Two's complement negation.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // Magnitude of an operand; only negative values in signed mode are flipped.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (sgn && (sv < 0)) ? f_neg(v) : v;
  endfunction

  // Conditional negation used when applying the latched result signs.
  function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? f_neg(v) : v;
  endfunction

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;     // partial remainder
  logic [WIDTH-1:0]   quo_q,    quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dsr_q,    dsr_d;     // divisor magnitude
  logic               qneg_q,   qneg_d;
  logic               rneg_q,   rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q,  ready_d;

  logic [WIDTH:0]          shifted;
  logic signed [WIDTH+1:0] trial;
  logic                    trial_neg;
  logic [WIDTH-1:0]        rem_iter;
  logic [WIDTH-1:0]        quo_iter;

  always_comb begin
    // One restoring step: bring the next dividend bit into the remainder and
    // try to subtract. shifted < 2*divisor always holds, so W+1 bits suffice
    // and one extra bit carries the trial sign.
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = $signed({1'b0, shifted}) - $signed({2'b00, dsr_q});
    trial_neg = trial[WIDTH+1];
    rem_iter  = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_iter  = {quo_q[WIDTH-2:0], ~trial_neg};

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            rem_d   = '0;
            quo_d   = f_mag(opdata1_i, signed_div_i);
            dsr_d   = f_mag(opdata2_i, signed_div_i);
            // Signs only matter for DIV; DIVU results are never negated.
            qneg_d  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rneg_d  = signed_div_i & opdata1_i[WIDTH-1];
            cnt_d   = '0;
          end
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          rem_d = rem_iter;
          quo_d = quo_iter;
          cnt_d = cnt_q + CNT_ONE;
          // Last iteration: fold the sign fix-up into the same edge so ready_o
          // rises right after the WIDTH-th step.
          if (cnt_q == CNT_LAST) begin
            state_d  = S_END;
            result_d = {f_apply_sign(rem_iter, rneg_q), f_apply_sign(quo_iter, qneg_q)};
            ready_d  = 1'b1;
          end
        end
      end

      S_END: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: scoreboard bench for hilo_divider. The driver issues divide
// requests and pushes the arithmetic reference result; an independent monitor
// pops and compares every time ready_o rises.
module tb_hilo_divider;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           sgn;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic           start;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [2*W-1:0] sb_q[$];

  hilo_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (sgn),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference: plain integer division in 64-bit arithmetic. Signed '/' and '%'
  // truncate toward zero with the remainder following the dividend; the
  // most-negative / -1 case yields +2^31, whose low 32 bits are 0x80000000.
  function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint la, lb, lq, lr;
    logic [63:0] uq, ur;
    if (b == 0) return '0;
    la = s ? longint'($signed(a)) : longint'({32'b0, a});
    lb = s ? longint'($signed(b)) : longint'({32'b0, b});
    lq = la / lb;
    lr = la % lb;
    uq = lq;
    ur = lr;
    return {ur[W-1:0], uq[W-1:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding request.
  initial begin : monitor
    logic prev;
    logic [2*W-1:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready === 1'b1 && prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", {63'b0, ready}, '0);
        end else begin
          exp = sb_q.pop_front();
          chk("sb_result", result, exp);
        end
      end
      prev = ready;
    end
  end

  // Full request handshake: hold start until ready, check latency, check the
  // result holds in END (annul ignored there), then drop start and check clear.
  task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    int edges;
    logic [2*W-1:0] exp;
    exp = ref_div(s, a, b);
    sb_q.push_back(exp);
    sgn = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (scramble) begin
        sgn = 1'($urandom); op1 = $urandom; op2 = $urandom;
      end
    end while (ready !== 1'b1 && edges < 100);
    chk("latency", 64'(edges), (b == 0) ? 64'd2 : 64'd33);
    annul = 1'b1;
    @(posedge clk); #1;
    chk("end_hold_ready", {63'b0, ready}, 64'd1);
    chk("end_hold_result", result, exp);
    annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("drop_ready", {63'b0, ready}, '0);
    chk("drop_result", result, '0);
  endtask

  // Watch for a number of cycles; ready_o must never rise.
  task automatic expect_quiet(input string nm, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (ready !== 1'b0 || result !== '0) seen = 1'b1;
    end
    chk(nm, {63'b0, seen}, '0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst = 1'b1; sgn = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'b0, ready}, '0);
    chk("reset_result", result, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the plan.
    do_div(1'b0, 32'd7, 32'd2, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'd0, 1'b0);

    // annul held alongside start in IDLE blocks the request.
    sgn = 1'b0; op1 = 32'd100; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; annul = 1'b0;
    expect_quiet("annul_blocks_start", 40);

    // annul at iteration 10.
    sgn = 1'b0; op1 = 32'd100; op2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_ready", {63'b0, ready}, '0);
    chk("annul_result", result, '0);
    expect_quiet("annul_quiet", 40);
    do_div(1'b0, 32'd100, 32'd3, 1'b0);

    // annul while in BYZERO.
    sgn = 1'b0; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    expect_quiet("annul_byzero_quiet", 10);

    // Operands and mode change every cycle after the start edge.
    do_div(1'b0, 32'd100, 32'd7, 1'b1);

    // Reset in the middle of an operation.
    sgn = 1'b1; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", {63'b0, ready}, '0);
    chk("rst_mid_result", result, '0);
    expect_quiet("rst_mid_quiet", 40);

    // Randomised requests.
    for (int i = 0; i < 24; i++) begin
      logic s;
      logic [W-1:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_div(s, a, b, 1'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
